// File: rtl/cache_bus_mem_responder.sv
// Cache-bus memory responder: a word-addressed backing array served by
// independent read and write state machines (one outstanding transaction each).
module cache_bus_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   // write address channel
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [ADDR_WIDTH-1:0]     aw_addr,
   input  logic [ID_WIDTH-1:0]       aw_id,
   input  logic [7:0]                aw_len,
   input  logic [2:0]                aw_size,
   input  logic [1:0]                aw_burst,
   input  logic [3:0]                aw_snoop,
   input  logic [USER_WIDTH-1:0]     aw_user,
   // write data channel
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [DATA_WIDTH-1:0]     w_data,
   input  logic [DATA_WIDTH/8-1:0]   w_strb,
   input  logic                      w_last,
   input  logic [USER_WIDTH-1:0]     w_user,
   // write response channel
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic [ID_WIDTH-1:0]       b_id,
   output logic [1:0]                b_resp,
   output logic [USER_WIDTH-1:0]     b_user,
   // read address channel
   input  logic                      ar_valid,
   output logic                      ar_ready,
   input  logic [ADDR_WIDTH-1:0]     ar_addr,
   input  logic [ID_WIDTH-1:0]       ar_id,
   input  logic [7:0]                ar_len,
   input  logic [2:0]                ar_size,
   input  logic [1:0]                ar_burst,
   input  logic [3:0]                ar_snoop,
   input  logic [USER_WIDTH-1:0]     ar_user,
   // read data channel
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic [ID_WIDTH-1:0]       r_id,
   output logic [1:0]                r_resp,
   output logic                      r_last,
   output logic [USER_WIDTH-1:0]     r_user
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned OFFS_W     = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   r_state_t r_state, r_state_next;
   w_state_t w_state, w_state_next;

   logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic [IDX_W-1:0] ar_word, aw_word;
   logic [IDX_W-1:0] r_idx, r_idx_inc, w_idx, w_idx_inc;
   logic [7:0]       r_len, r_cnt, r_cnt_inc;
   logic [1:0]       r_burst, w_burst;

   // Size, snoop, write-side user and aw_len carry no meaning here; upper
   // address bits are dropped so addresses alias onto the array.
   logic unused_fields;
   assign unused_fields = ^{aw_addr, ar_addr, aw_size, ar_size, aw_snoop,
                            ar_snoop, aw_user, w_user, aw_len};

   assign ar_word = ar_addr[OFFS_W +: IDX_W];
   assign aw_word = aw_addr[OFFS_W +: IDX_W];

   assign ar_hs = ar_valid & ar_ready;
   assign r_hs  = r_valid & r_ready;
   assign aw_hs = aw_valid & aw_ready;
   assign w_hs  = w_valid & w_ready;
   assign b_hs  = b_valid & b_ready;

   // FIXED bursts stay on one word; INCR and WRAP both step and wrap the index
   assign r_idx_inc = (r_burst != 2'd0) ? IDX_W'(r_idx + IDX_W'(1)) : r_idx;
   assign w_idx_inc = (w_burst != 2'd0) ? IDX_W'(w_idx + IDX_W'(1)) : w_idx;
   assign r_cnt_inc = r_cnt + 8'd1;

   assign r_resp = 2'd0;
   assign b_resp = 2'd0;
   assign b_user = '0;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_state_next;
   end

   // Read FSM next state
   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_next = R_BURST;
         R_BURST: if (r_hs && r_last) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Read datapath: r_data is captured at the handshake that selects the word,
   // so it stays stable under backpressure and a same-edge write is not seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         ar_ready <= 1'b1;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_data   <= '0;
         r_id     <= '0;
         r_user   <= '0;
         r_len    <= '0;
         r_burst  <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
      end else begin
         ar_ready <= (r_state_next == R_IDLE);
         r_valid  <= (r_state_next == R_BURST);
         if (ar_hs) begin
            r_id    <= ar_id;
            r_user  <= ar_user;
            r_len   <= ar_len;
            r_burst <= ar_burst;
            r_idx   <= ar_word;
            r_cnt   <= '0;
            r_data  <= mem[ar_word];
            r_last  <= (ar_len == 8'd0);
         end else if (r_hs) begin
            r_idx  <= r_idx_inc;
            r_cnt  <= r_cnt_inc;
            r_data <= mem[r_idx_inc];
            r_last <= !r_last && (r_cnt_inc == r_len);
         end
      end
   end

   // Write FSM state register
   always_ff @(posedge clk) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_state_next;
   end

   // Write FSM next state; w_last alone ends the data phase
   always_comb begin
      w_state_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_state_next = W_DATA;
         W_DATA:  if (w_hs && w_last) w_state_next = W_RESP;
         W_RESP:  if (b_hs) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Write control and latched address fields
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_ready <= 1'b1;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_id     <= '0;
         w_burst  <= '0;
         w_idx    <= '0;
      end else begin
         aw_ready <= (w_state_next == W_IDLE);
         w_ready  <= (w_state_next == W_DATA);
         b_valid  <= (w_state_next == W_RESP);
         if (aw_hs) begin
            b_id    <= aw_id;
            w_burst <= aw_burst;
            w_idx   <= aw_word;
         end else if (w_hs) begin
            w_idx <= w_idx_inc;
         end
      end
   end

   // Byte-strobed array write; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && w_hs) begin
         for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
            if (w_strb[k]) mem[w_idx][k*8 +: 8] <= w_data[k*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Directed and randomized bench for cache_bus_mem_responder against an
// array-based model of the backing memory.
module tb_cache_bus_mem_responder;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;
   localparam int unsigned UW = 1;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic aw_valid, aw_ready; logic [AW-1:0] aw_addr; logic [IW-1:0] aw_id;
   logic [7:0] aw_len; logic [2:0] aw_size; logic [1:0] aw_burst;
   logic [3:0] aw_snoop; logic [UW-1:0] aw_user;
   logic w_valid, w_ready; logic [DW-1:0] w_data; logic [SW-1:0] w_strb;
   logic w_last; logic [UW-1:0] w_user;
   logic b_valid, b_ready; logic [IW-1:0] b_id; logic [1:0] b_resp; logic [UW-1:0] b_user;
   logic ar_valid, ar_ready; logic [AW-1:0] ar_addr; logic [IW-1:0] ar_id;
   logic [7:0] ar_len; logic [2:0] ar_size; logic [1:0] ar_burst;
   logic [3:0] ar_snoop; logic [UW-1:0] ar_user;
   logic r_valid, r_ready; logic [DW-1:0] r_data; logic [IW-1:0] r_id;
   logic [1:0] r_resp; logic r_last; logic [UW-1:0] r_user;

   always #5 clk = ~clk;

   cache_bus_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MEM_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_snoop(aw_snoop),
      .aw_user(aw_user),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .w_last(w_last), .w_user(w_user),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_snoop(ar_snoop),
      .ar_user(ar_user),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
      .r_resp(r_resp), .r_last(r_last), .r_user(r_user)
   );

   // Reference memory and bookkeeping
   logic [DW-1:0] mem_m [DEPTH];
   int unsigned n_pass = 0, n_fail = 0, n_total = 0;
   logic [DW-1:0] wd_q[$];
   logic [SW-1:0] ws_q[$];
   logic [DW-1:0] rd_q[$];
   bit rdy_q[$];
   bit rand_ready = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned word_of(input logic [AW-1:0] a);
      return (int'(a) / SW) % DEPTH;
   endfunction

   function automatic int unsigned next_word(input int unsigned w, input logic [1:0] burst);
      return (burst == 2'd0) ? w : (w + 1) % DEPTH;
   endfunction

   task automatic model_write(input int unsigned w, input logic [DW-1:0] d, input logic [SW-1:0] s);
      for (int k = 0; k < int'(SW); k++)
         if (s[k]) mem_m[w][k*8 +: 8] = d[k*8 +: 8];
   endtask

   // Write burst from wd_q/ws_q; optional random w_valid gaps
   task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [IW-1:0] id, input bit gaps);
      int unsigned w = word_of(addr);
      int unsigned beat = 0;
      int unsigned cyc = 0;
      bit v, hs;
      @(negedge clk);
      check("aw_ready_idle", 64'(aw_ready), 64'd1);
      aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_burst = burst; aw_id = id;
      aw_size = 3'($urandom); aw_snoop = 4'($urandom); aw_user = UW'($urandom);
      @(posedge clk);
      @(negedge clk);
      aw_valid = 1'b0;
      while (beat <= int'(len) && cyc < 8 * (int'(len) + 1) + 16) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         w_valid = v; w_data = wd_q[beat]; w_strb = ws_q[beat];
         w_last = (beat == int'(len)); w_user = UW'($urandom);
         hs = v && w_ready;
         @(posedge clk);
         if (hs) begin
            model_write(w, wd_q[beat], ws_q[beat]);
            w = next_word(w, burst);
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      w_valid = 1'b0; w_last = 1'b0;
      check("w_beats_accepted", 64'(beat), 64'(len) + 64'd1);
      check("b_valid", 64'(b_valid), 64'd1);
      check("b_id", 64'(b_id), 64'(id));
      check("b_resp", 64'(b_resp), 64'd0);
      check("b_user", 64'(b_user), 64'd0);
      check("w_ready_in_resp", 64'(w_ready), 64'd0);
      b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_ready = 1'b0;
      check("b_valid_cleared", 64'(b_valid), 64'd0);
      check("aw_ready_back", 64'(aw_ready), 64'd1);
   endtask

   // Read burst; r_ready from rdy_q, else random or always-high
   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [IW-1:0] id);
      int unsigned w = word_of(addr);
      int unsigned stall;
      bit rdy;
      rd_q.delete();
      @(negedge clk);
      check("ar_ready_idle", 64'(ar_ready), 64'd1);
      ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id;
      ar_size = 3'($urandom); ar_snoop = 4'($urandom); ar_user = UW'($urandom);
      @(posedge clk);
      @(negedge clk);
      ar_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         stall = 0;
         forever begin
            if (rdy_q.size() != 0) rdy = rdy_q.pop_front();
            else if (rand_ready)   rdy = ($urandom_range(0, 1) == 1);
            else                   rdy = 1'b1;
            if (stall >= 8) rdy = 1'b1;
            r_ready = rdy;
            check("r_valid", 64'(r_valid), 64'd1);
            check("r_data", 64'(r_data), 64'(mem_m[w]));
            check("r_id", 64'(r_id), 64'(id));
            check("r_user", 64'(r_user), 64'(ar_user));
            check("r_last", 64'(r_last), 64'(b == int'(len)));
            check("r_resp", 64'(r_resp), 64'd0);
            if (rdy) rd_q.push_back(r_data);
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            stall++;
         end
         w = next_word(w, burst);
      end
      r_ready = 1'b0;
      check("r_valid_after_burst", 64'(r_valid), 64'd0);
      check("ar_ready_after_burst", 64'(ar_ready), 64'd1);
   endtask

   task automatic load_queue(input int unsigned n, input bit rand_strb);
      wd_q.delete(); ws_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         wd_q.push_back({$urandom, $urandom});
         ws_q.push_back(rand_strb ? SW'($urandom) : {SW{1'b1}});
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] old_val, new_val, d0, d1;
      logic [AW-1:0] addr, last_addr;
      logic [7:0] len;
      logic [1:0] burst;

      rst = 1'b1;
      aw_valid = 0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
      aw_snoop = '0; aw_user = '0;
      w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; w_user = '0; b_ready = 0;
      ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
      ar_snoop = '0; ar_user = '0; r_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ar_ready", 64'(ar_ready), 64'd1);
      check("rst_aw_ready", 64'(aw_ready), 64'd1);
      check("rst_r_valid", 64'(r_valid), 64'd0);
      check("rst_w_ready", 64'(w_ready), 64'd0);
      check("rst_b_valid", 64'(b_valid), 64'd0);
      check("rst_r_last", 64'(r_last), 64'd0);
      check("rst_b_resp", 64'(b_resp), 64'd0);
      check("rst_r_resp", 64'(r_resp), 64'd0);
      rst = 1'b0;

      // Fill the whole array so every later read has a known model value
      for (int c = 0; c < 4; c++) begin
         load_queue(256, 1'b0);
         do_write(AW'(c * 256 * SW), 8'd255, 2'd1, IW'(c), 1'b1);
      end

      // Four-beat INCR write at 0x40 then read back
      wd_q = '{64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444};
      ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      do_write(32'h40, 8'd3, 2'd1, 4'd5, 1'b0);
      do_read(32'h40, 8'd3, 2'd1, 4'd2);
      for (int i = 0; i < 4; i++)
         check("incr_read_beat", 64'(rd_q[i]), 64'h1111111111111111 * 64'(i + 1));

      // Partial strobe keeps the upper half
      wd_q = '{64'hAAAAAAAA_BBBBBBBB};
      ws_q = '{8'h0F};
      do_write(32'h40, 8'd0, 2'd1, 4'd6, 1'b0);
      do_read(32'h40, 8'd0, 2'd1, 4'd1);
      check("strb_merge", 64'(rd_q[0]), 64'h11111111_BBBBBBBB);

      // Backpressure pattern 1,0,0,1
      rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_read(32'h40, 8'd3, 2'd1, 4'd7);
      check("stall_beat_count", 64'(rd_q.size()), 64'd4);
      check("stall_beat0", 64'(rd_q[0]), 64'h11111111_BBBBBBBB);
      check("stall_beat1", 64'(rd_q[1]), 64'h2222222222222222);
      check("stall_beat2", 64'(rd_q[2]), 64'h3333333333333333);
      check("stall_beat3", 64'(rd_q[3]), 64'h4444444444444444);

      // FIXED burst stays on word 9; INCR wraps from the last word to word 0
      do_read(AW'(9 * SW), 8'd2, 2'd0, 4'd3);
      for (int i = 0; i < 3; i++)
         check("fixed_beat", 64'(rd_q[i]), 64'h2222222222222222);
      do_read(AW'((DEPTH - 1) * SW), 8'd1, 2'd1, 4'd4);
      check("wrap_beat1", 64'(rd_q[1]), 64'(mem_m[0]));

      // Read address and write beat on word 20 at the same edge
      old_val = mem_m[20];
      new_val = {$urandom, $urandom};
      @(negedge clk);
      aw_valid = 1; aw_addr = AW'(20 * SW); aw_len = 0; aw_burst = 2'd1; aw_id = 4'd3;
      @(posedge clk);
      @(negedge clk);
      aw_valid = 0;
      check("coll_w_ready", 64'(w_ready), 64'd1);
      check("coll_ar_ready", 64'(ar_ready), 64'd1);
      w_valid = 1; w_data = new_val; w_strb = 8'hFF; w_last = 1;
      ar_valid = 1; ar_addr = AW'(20 * SW); ar_len = 0; ar_burst = 2'd1; ar_id = 4'd9;
      @(posedge clk);
      model_write(20, new_val, 8'hFF);
      @(negedge clk);
      w_valid = 0; w_last = 0; ar_valid = 0;
      check("coll_r_valid", 64'(r_valid), 64'd1);
      check("coll_pre_write_data", 64'(r_data), 64'(old_val));
      check("coll_b_valid", 64'(b_valid), 64'd1);
      r_ready = 1; b_ready = 1;
      @(posedge clk);
      @(negedge clk);
      r_ready = 0; b_ready = 0;
      do_read(AW'(20 * SW), 8'd0, 2'd1, 4'd1);
      check("coll_post_write_data", 64'(rd_q[0]), 64'(new_val));

      // Concurrent read and write on disjoint regions
      load_queue(8, 1'b1);
      rand_ready = 1'b1;
      fork
         do_write(AW'(100 * SW), 8'd7, 2'd1, 4'd12, 1'b1);
         do_read(AW'(300 * SW), 8'd7, 2'd1, 4'd13);
      join
      rand_ready = 1'b0;
      do_read(AW'(100 * SW), 8'd7, 2'd1, 4'd14);

      // Randomized traffic with aliasing addresses, random bursts and strobes
      last_addr = 32'h40;
      for (int it = 0; it < 40; it++) begin
         len = 8'($urandom_range(0, 15));
         burst = 2'($urandom_range(0, 3));
         if (it % 2 == 0) begin
            addr = $urandom;
            last_addr = addr;
            load_queue(int'(len) + 1, 1'b1);
            do_write(addr, len, burst, IW'($urandom), 1'b1);
         end else begin
            addr = ($urandom_range(0, 1) == 1) ? last_addr : $urandom;
            rand_ready = 1'b1;
            do_read(addr, len, burst, IW'($urandom));
            rand_ready = 1'b0;
         end
      end

      // Reset during beat 2 of a four-beat read
      @(negedge clk);
      ar_valid = 1; ar_addr = 32'h40; ar_len = 3; ar_burst = 2'd1; ar_id = 4'd8;
      @(posedge clk);
      @(negedge clk);
      ar_valid = 0; r_ready = 1;
      check("mid_rst_beat1_valid", 64'(r_valid), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_beat2_data", 64'(r_data), 64'(mem_m[9]));
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      check("mid_rst_r_valid", 64'(r_valid), 64'd0);
      check("mid_rst_ar_ready", 64'(ar_ready), 64'd1);
      check("mid_rst_r_last", 64'(r_last), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_no_beat", 64'(r_valid), 64'd0);
      end
      r_ready = 0;
      do_read(32'h40, 8'd3, 2'd1, 4'd4);

      // Reset after two of four write beats; written bytes remain
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      @(negedge clk);
      aw_valid = 1; aw_addr = AW'(50 * SW); aw_len = 3; aw_burst = 2'd1; aw_id = 4'd2;
      @(posedge clk);
      @(negedge clk);
      aw_valid = 0;
      check("wrst_w_ready", 64'(w_ready), 64'd1);
      w_valid = 1; w_data = d0; w_strb = 8'hFF; w_last = 0;
      @(posedge clk);
      model_write(50, d0, 8'hFF);
      @(negedge clk);
      w_data = d1;
      @(posedge clk);
      model_write(51, d1, 8'hFF);
      @(negedge clk);
      w_valid = 0;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      check("wrst_b_valid", 64'(b_valid), 64'd0);
      check("wrst_w_ready_low", 64'(w_ready), 64'd0);
      check("wrst_aw_ready", 64'(aw_ready), 64'd1);
      do_read(AW'(50 * SW), 8'd1, 2'd1, 4'd0);
      check("wrst_kept_word50", 64'(rd_q[0]), 64'(d0));
      check("wrst_kept_word51", 64'(rd_q[1]), 64'(d1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
